ldpc_iter_ctrl: RTL and testbench
=================================

Name: ldpc_iter_ctrl

Overview:
- Iteration controller and result buffer for the LDPC decoder core. Sequences one codeword decode: start handshake, LLR load strobe, per-iteration enable, early termination on syndrome pass, and hard-decision capture into a valid/ready output buffer.
- Generalises the old fixed-count terminate logic:
  - run-time programmable iteration limit;
  - configurable number of consecutive syndrome passes before stopping;
  - abort;
  - iteration count report;
  - back-pressured result.

Parameters:
- N_BITS, 2304, codeword length in bits (R*D of the core).
- ITER_W, 6, iteration counter width; limit range is 1..2^ITER_W.
- CONFIRM, 1, consecutive syndrome passes required for early termination (>=1).
- PASS_W, 2, width of pass counter; must satisfy 2^PASS_W > CONFIRM.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  decode request; accepted only in IDLE.
- max_iter  in  ITER_W  iteration limit, sampled on start accept; 0 encodes 2^ITER_W.
- abort  in  1  cancel current decode.
- dec  in  N_BITS  hard decisions from VNU array.
- check  in  1  syndrome flag from checker; 1 = parity fails, 0 = valid codeword.
- load  out  1  one-cycle strobe: VNU array captures channel LLRs.
- dec_en  out  1  enable to CNU array; high for every iteration cycle.
- busy  out  1  high in LOAD and RUN.
- res  out  N_BITS  captured hard decisions.
- err  out  1  1 = result failed parity at termination.
- iters  out  ITER_W+1  number of RUN cycles executed for the captured result.
- res_valid  out  1  result buffer holds an unconsumed result.
- res_ready  in  1  consumer accepts result.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, load=0, dec_en=0, busy=0, res=0, err=0, iters=0, res_valid=0, internal counters 0. Deassertion is synchronous to clk.
- States: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - start=1 -> LOAD.
  - Latch lim = (max_iter==0) ? 2^ITER_W : max_iter, held in ITER_W+1 bits.
  - Clear it_cnt and pass_cnt.
- LOAD: load=1 for exactly one cycle, busy=1 -> RUN next cycle.
- RUN:
  - dec_en=1 and busy=1 each cycle; it_cnt increments each cycle.
  - Each cycle evaluates n = it_cnt+1.
  - pass_cnt increments when check=0 and clears when check=1.
  - Success: check=0 and pass_cnt==CONFIRM-1 -> capture res<=dec, err<=0, iters<=n; go to HOLD.
  - Limit: otherwise, if n==lim -> capture res<=dec, err<=check, iters<=n; go to HOLD.
  - Success has priority over limit in the same cycle.
- HOLD:
  - res_valid=1; res, err and iters stable.
  - res_ready=1 -> res_valid<=0, go to IDLE.
  - start is ignored in HOLD, including the cycle res_ready fires; a new start is accepted from the following IDLE cycle.
- Abort:
  - In LOAD or RUN: -> IDLE next cycle; res, err, iters and res_valid unchanged; counters cleared.
  - Abort has priority over both termination conditions in the same cycle.
  - Ignored in IDLE and HOLD.
- Latency from start accept to res_valid: 2 + iters cycles. Minimum is 3 cycles (success on first RUN cycle with CONFIRM=1).
- res and iters change only on a capture; they persist in IDLE until the next capture.
- No arithmetic wrap: lim <= 2^ITER_W, so it_cnt never exceeds lim-1.
- Reset mid-operation: immediate return to reset values; an in-flight result is discarded.

Test Plan:
- ITER_W=6, CONFIRM=1, max_iter=10; check=1 throughout, dec=pattern A -> load pulse 1 cycle, dec_en high 10 cycles, res=A, err=1, iters=10, res_valid 12 cycles after start.
- max_iter=10; check falls to 0 on the 4th RUN cycle, dec=B -> res=B, err=0, iters=4; dec_en high exactly 4 cycles.
- CONFIRM=2, max_iter=20; check pattern 1,0,1,0,0 -> terminates on the 5th RUN cycle, err=0, iters=5.
- max_iter=0; check=1 always -> 64 RUN cycles, iters=64, err=1.
- Abort on the 3rd RUN cycle -> IDLE next cycle, res_valid stays 0, previous res/iters unchanged. Then start with max_iter=5 -> iters=5.
- Result in HOLD with res_ready=0 for 7 cycles while start pulses -> res_valid held, start ignored. res_ready=1 with start=1 in the same cycle -> IDLE, no decode. start next cycle -> LOAD. Async rst low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/ldpc_iter_ctrl_if.sv
// Handshake and data bundle between the LDPC iteration controller and its surroundings.
// The controller side is the slave modport; master is the environment driving it.
interface ldpc_iter_ctrl_if #(
  parameter int N_BITS = 2304,
  parameter int ITER_W = 6
);
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              abort;
  logic [N_BITS-1:0] dec;
  logic              check;
  logic              load;
  logic              dec_en;
  logic              busy;
  logic [N_BITS-1:0] res;
  logic              err;
  logic [ITER_W:0]   iters;
  logic              res_valid;
  logic              res_ready;

  // Result handshake: a result transfers on a rising edge where res_valid and
  // res_ready are both high; res/err/iters stay stable while res_valid is high.
  modport master (
    output start, max_iter, abort, dec, check, res_ready,
    input  load, dec_en, busy, res, err, iters, res_valid
  );

  modport slave (
    input  start, max_iter, abort, dec, check, res_ready,
    output load, dec_en, busy, res, err, iters, res_valid
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decode iteration controller: start/load/run sequencing with early
// termination on consecutive syndrome passes and a back-pressured result buffer.
module ldpc_iter_ctrl #(
  parameter int N_BITS  = 2304,
  parameter int ITER_W  = 6,
  parameter int CONFIRM = 1,
  parameter int PASS_W  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ldpc_iter_ctrl_if.slave     bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_e;

  localparam logic [ITER_W:0]   LIM_MAX   = {1'b1, {ITER_W{1'b0}}};
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(CONFIRM - 1);

  state_e              state_q, state_d;
  logic [ITER_W:0]     lim_q;
  logic [ITER_W:0]     it_cnt_q;
  logic [PASS_W-1:0]   pass_cnt_q;
  logic [N_BITS-1:0]   res_q;
  logic                err_q;
  logic [ITER_W:0]     iters_q;
  logic                res_valid_q;

  logic [ITER_W:0]     n_iter;
  logic                success;
  logic                limit;
  logic                load, dec_en, busy, capture;

  // n_iter is the 1-based index of the current RUN cycle.
  assign n_iter  = it_cnt_q + (ITER_W+1)'(1);
  assign success = !bus.check && (pass_cnt_q == PASS_LAST);
  assign limit   = (n_iter == lim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: state_d = bus.abort ? IDLE : RUN;
      RUN: begin
        if (bus.abort)             state_d = IDLE;
        else if (success || limit) state_d = HOLD;
      end
      HOLD: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    dec_en  = 1'b0;
    busy    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      RUN: begin
        dec_en  = 1'b1;
        busy    = 1'b1;
        capture = !bus.abort && (success || limit);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_q       <= '0;
      it_cnt_q    <= '0;
      pass_cnt_q  <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      iters_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          lim_q      <= (bus.max_iter == '0) ? LIM_MAX : {1'b0, bus.max_iter};
          it_cnt_q   <= '0;
          pass_cnt_q <= '0;
        end
        LOAD: if (bus.abort) begin
          it_cnt_q   <= '0;
          pass_cnt_q <= '0;
        end
        RUN: begin
          if (bus.abort) begin
            it_cnt_q   <= '0;
            pass_cnt_q <= '0;
          end else begin
            it_cnt_q   <= n_iter;
            pass_cnt_q <= bus.check ? '0 : pass_cnt_q + PASS_W'(1);
          end
          if (capture) begin
            res_q       <= bus.dec;
            err_q       <= success ? 1'b0 : bus.check;
            iters_q     <= n_iter;
            res_valid_q <= 1'b1;
          end
        end
        HOLD: if (bus.res_ready) res_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.load      = load;
  assign bus.dec_en    = dec_en;
  assign bus.busy      = busy;
  assign bus.res       = res_q;
  assign bus.err       = err_q;
  assign bus.iters     = iters_q;
  assign bus.res_valid = res_valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Bench for ldpc_iter_ctrl: two instances (CONFIRM=1 and CONFIRM=2) share one
// stimulus stream; table vectors plus hand sequences for abort, HOLD and reset.
module tb_ldpc_iter_ctrl;
  localparam int N  = 64;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, abort, check, res_ready;
  logic [IW-1:0] max_iter;
  logic [N-1:0]  dec;
  logic [1:0]    st1, st2;

  ldpc_iter_ctrl_if #(.N_BITS(N), .ITER_W(IW)) b1 ();
  ldpc_iter_ctrl_if #(.N_BITS(N), .ITER_W(IW)) b2 ();

  assign b1.start = start;  assign b2.start = start;
  assign b1.abort = abort;  assign b2.abort = abort;
  assign b1.check = check;  assign b2.check = check;
  assign b1.dec   = dec;    assign b2.dec   = dec;
  assign b1.max_iter  = max_iter;  assign b2.max_iter  = max_iter;
  assign b1.res_ready = res_ready; assign b2.res_ready = res_ready;

  ldpc_iter_ctrl #(.N_BITS(N), .ITER_W(IW), .CONFIRM(1), .PASS_W(2))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .state_o(st1));
  ldpc_iter_ctrl #(.N_BITS(N), .ITER_W(IW), .CONFIRM(2), .PASS_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave), .state_o(st2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mask bit k-1 is the check value applied on RUN cycle k
  typedef struct {
    logic [IW-1:0] max_iter;
    logic [63:0]   mask;
    logic [63:0]   dec;
    logic          err1;
    int            iters1;
    logic          err2;
    int            iters2;
  } vec_t;

  vec_t vecs[7];

  task automatic outputs_zero(input string tag);
    chk({tag, " d1 outs"}, {b1.load, b1.dec_en, b1.busy, b1.err, b1.res_valid}, 64'h0);
    chk({tag, " d1 res"}, b1.res, 64'h0);
    chk({tag, " d1 iters"}, 64'(b1.iters), 64'h0);
    chk({tag, " d2 outs"}, {b2.load, b2.dec_en, b2.busy, b2.err, b2.res_valid}, 64'h0);
    chk({tag, " d2 res"}, b2.res, 64'h0);
    chk({tag, " d2 iters"}, 64'(b2.iters), 64'h0);
  endtask

  // Start a decode and wait for both results; optionally consume them.
  task automatic run_vec(input string tag, input logic [IW-1:0] mi, input logic [63:0] mask,
                         input logic [63:0] d, input logic e1, input int i1,
                         input logic e2, input int i2, input bit consume);
    int k = 0, lat1 = 0, lat2 = 0, den1 = 0, den2 = 0, ld1 = 0, ld2 = 0;
    bit done = 0;
    @(negedge clk);
    start = 1'b1; max_iter = mi; dec = d; check = 1'b1;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (b1.load) ld1++;
      if (b2.load) ld2++;
      if (b1.dec_en) den1++;
      if (b2.dec_en) den2++;
      if (b1.res_valid && lat1 == 0) lat1 = cyc;
      if (b2.res_valid && lat2 == 0) lat2 = cyc;
      if (b1.dec_en || b2.dec_en) begin
        k++;
        check = mask[k-1];
      end
      done = (lat1 != 0) && (lat2 != 0);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: lat1=%0d lat2=%0d expected both valid", tag, lat1, lat2);
      return;
    end
    chk({tag, " d1 res"}, b1.res, d);
    chk({tag, " d1 err"}, 64'(b1.err), 64'(e1));
    chk({tag, " d1 iters"}, 64'(b1.iters), 64'(i1));
    chk({tag, " d1 latency"}, 64'(lat1), 64'(2 + i1));
    chk({tag, " d1 dec_en cycles"}, 64'(den1), 64'(i1));
    chk({tag, " d1 load cycles"}, 64'(ld1), 64'd1);
    chk({tag, " d2 res"}, b2.res, d);
    chk({tag, " d2 err"}, 64'(b2.err), 64'(e2));
    chk({tag, " d2 iters"}, 64'(b2.iters), 64'(i2));
    chk({tag, " d2 latency"}, 64'(lat2), 64'(2 + i2));
    chk({tag, " d2 dec_en cycles"}, 64'(den2), 64'(i2));
    chk({tag, " d2 load cycles"}, 64'(ld2), 64'd1);
    if (consume) begin
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, " valid cleared"}, {62'h0, b1.res_valid, b2.res_valid}, 64'h0);
    end
  endtask

  initial begin
    start = 0; abort = 0; check = 1; res_ready = 0; max_iter = '0; dec = '0;

    vecs[0] = '{6'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_0F0F_1234_5678, 1'b1, 10, 1'b1, 10};
    vecs[1] = '{6'd10, 64'h7,                   64'hB0B1_B2B3_C0DE_CAFE, 1'b0,  4, 1'b0,  5};
    vecs[2] = '{6'd20, 64'h5,                   64'h0123_4567_89AB_CDEF, 1'b0,  2, 1'b0,  5};
    vecs[3] = '{6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 64, 1'b1, 64};
    vecs[4] = '{6'd3,  ~64'h2,                  64'h1111_2222_3333_4444, 1'b0,  2, 1'b1,  3};
    vecs[5] = '{6'd1,  64'h0,                   64'h8000_0000_0000_0001, 1'b0,  1, 1'b0,  1};
    vecs[6] = '{6'd2,  64'h2,                   64'h5555_AAAA_5555_AAAA, 1'b0,  1, 1'b1,  2};

    #1;
    outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].max_iter, vecs[i].mask, vecs[i].dec,
              vecs[i].err1, vecs[i].iters1, vecs[i].err2, vecs[i].iters2, 1'b1);

    // Abort on the 3rd RUN cycle: previous result must persist.
    @(negedge clk);
    start = 1'b1; max_iter = 6'd10; check = 1'b1; dec = 64'hFACE_FACE_FACE_FACE;
    @(posedge clk); @(negedge clk); start = 1'b0;  // LOAD
    for (int c = 0; c < 3; c++) begin @(posedge clk); @(negedge clk); end
    chk("abort pre dec_en", {62'h0, b1.dec_en, b2.dec_en}, 64'h3);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort busy", {62'h0, b1.busy, b2.busy}, 64'h0);
    chk("abort state", {60'h0, st1, st2}, 64'h0);
    chk("abort res_valid", {62'h0, b1.res_valid, b2.res_valid}, 64'h0);
    chk("abort d1 res kept", b1.res, vecs[6].dec);
    chk("abort d1 iters kept", 64'(b1.iters), 64'd1);
    chk("abort d2 iters kept", 64'(b2.iters), 64'd2);
    run_vec("post_abort", 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_F0F0_F0F0,
            1'b1, 5, 1'b1, 5, 1'b1);

    // Back-pressured HOLD with start pulses.
    run_vec("hold", 6'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7777_8888_9999_AAAA,
            1'b1, 2, 1'b1, 2, 1'b0);
    for (int c = 0; c < 7; c++) begin
      start = (c % 2 == 0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("hold%0d valid", c), {62'h0, b1.res_valid, b2.res_valid}, 64'h3);
      chk($sformatf("hold%0d busy", c), {60'h0, b1.busy, b2.busy, b1.load, b2.load}, 64'h0);
    end
    chk("hold d1 iters stable", 64'(b1.iters), 64'd2);
    start = 1'b1; res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    chk("ready+start state", {60'h0, st1, st2}, 64'h0);
    chk("ready+start outs", {60'h0, b1.res_valid, b1.load, b2.res_valid, b2.load}, 64'h0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start after hold load", {62'h0, b1.load, b2.load}, 64'h3);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("midrun dec_en", {62'h0, b1.dec_en, b2.dec_en}, 64'h3);
    #1 rst_n = 1'b0;
    #1;
    outputs_zero("async reset");
    chk("async reset state", {60'h0, st1, st2}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
